// File: rtl/vending_machine_param.sv
// vending_machine_param: coin-credit vending FSM with a parametrised price, a one-cycle vend pulse and serial 5c change.
// Optional VEND_COUNT_EN macro adds a wrapping vend counter output.
module vending_machine_param #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                coin_valid_i,
  input  logic [1:0]          coin_i,
  input  logic                cancel_i,
  output logic                vend_o,
  output logic                change_o,
  output logic                coin_reject_o,
  output logic                busy_o,
  output logic [CREDIT_W-1:0] credit_o
`ifdef VEND_COUNT_EN
  ,
  output logic [CNT_W-1:0]    vend_count_o
`endif
);
  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] VEND    = 2'd1;
  localparam logic [1:0] CHANGE  = 2'd2;
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  if (PRICE < 1 || PRICE > (1 << CREDIT_W) - 5 || CNT_W < 1) begin : g_bad_params
    $error("vending_machine_param: PRICE must be 1..2**CREDIT_W-5 and CNT_W >= 1");
  end
  logic [1:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W:0]   coin_val, sum;
  logic                accept;
  assign accept   = coin_valid_i && coin_i != 2'b00 && state_q == COLLECT;
  // 01 and 10 already encode 1 and 2 units; only the 25c code needs remapping
  assign coin_val = coin_i == 2'b11 ? (CREDIT_W+1)'(5) : {{(CREDIT_W-1){1'b0}}, coin_i};
  assign sum      = {1'b0, credit_q} + (accept ? coin_val : '0);
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    case (state_q)
      COLLECT: begin
        credit_d = sum[CREDIT_W-1:0];
        state_d  = sum >= PRICE_W ? VEND : (cancel_i && sum != '0) ? CHANGE : COLLECT;
      end
      VEND: begin
        credit_d = credit_q - PRICE_C;
        state_d  = credit_q != PRICE_C ? CHANGE : COLLECT;
      end
      CHANGE: begin
        credit_d = credit_q - 1'b1;
        state_d  = credit_q == CREDIT_W'(1) ? COLLECT : CHANGE;
      end
      default: begin
        credit_d = '0;
        state_d  = COLLECT;
      end
    endcase
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= COLLECT;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
    end
  end
  assign vend_o        = state_q == VEND;
  assign change_o      = state_q == CHANGE;
  assign busy_o        = state_q != COLLECT;
  assign coin_reject_o = coin_valid_i && coin_i != 2'b00 && state_q != COLLECT;
  assign credit_o      = credit_q;
`ifdef VEND_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else if (state_q == VEND) cnt_q <= cnt_q + 1'b1;
  end
  assign vend_count_o = cnt_q;
`endif
endmodule

// File: tb/tb_vending_machine_param.sv
// tb_vending_machine_param: directed scoreboard bench for vending_machine_param at PRICE=3.
module tb_vending_machine_param;
  typedef struct packed {
    logic       v;
    logic       ch;
    logic       b;
    logic       rej;
    logic [3:0] cr;
  } exp_t;
  logic       clk = 0, reset = 1, coin_valid = 0, cancel = 0;
  logic [1:0] coin = 2'b00;
  logic       vend, change, coin_reject, busy;
  logic [3:0] credit;
  int         checks = 0, errors = 0;
  exp_t       q[$];
`ifdef VEND_COUNT_EN
  logic [1:0] vend_count;
`endif
  vending_machine_param #(.PRICE(3), .CREDIT_W(4), .CNT_W(2)) dut (
    .clk_i(clk), .reset_i(reset), .coin_valid_i(coin_valid), .coin_i(coin), .cancel_i(cancel),
    .vend_o(vend), .change_o(change), .coin_reject_o(coin_reject), .busy_o(busy), .credit_o(credit)
`ifdef VEND_COUNT_EN
    , .vend_count_o(vend_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask
  // drive one cycle's inputs, queue what must be seen this cycle, compare at the falling edge
  task automatic step(input logic cv, input logic [1:0] c, input logic cn,
                      input logic v, input logic ch, input logic b, input logic rej, input logic [3:0] cr);
    exp_t e;
    coin_valid = cv;
    coin = c;
    cancel = cn;
    q.push_back('{v: v, ch: ch, b: b, rej: rej, cr: cr});
    @(negedge clk);
    e = q.pop_front();
    chk("vend", 8'(vend), 8'(e.v));
    chk("change", 8'(change), 8'(e.ch));
    chk("busy", 8'(busy), 8'(e.b));
    chk("coin_reject", 8'(coin_reject), 8'(e.rej));
    chk("credit", 8'(credit), 8'(e.cr));
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk("rst_vend", 8'(vend), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_credit", 8'(credit), 8'd0);
    chk("rst_change", 8'(change), 8'd0);
`ifdef VEND_COUNT_EN
    chk("rst_vend_count", 8'(vend_count), 8'd0);
`endif
    #10 reset = 0;
    @(posedge clk);
    #1;
    // three nickels, cancel during VEND ignored
    step(1, 2'b01, 0, 0, 0, 0, 0, 4'd0);
    step(1, 2'b01, 0, 0, 0, 0, 0, 4'd1);
    step(1, 2'b01, 0, 0, 0, 0, 0, 4'd2);
    step(0, 2'b00, 1, 1, 0, 1, 0, 4'd3);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // two dimes: one change pulse
    step(1, 2'b10, 0, 0, 0, 0, 0, 4'd0);
    step(1, 2'b10, 0, 0, 0, 0, 0, 4'd2);
    step(0, 2'b00, 0, 1, 0, 1, 0, 4'd4);
    step(0, 2'b00, 0, 0, 1, 1, 0, 4'd1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // quarter: two change pulses
    step(1, 2'b11, 0, 0, 0, 0, 0, 4'd0);
    step(0, 2'b00, 0, 1, 0, 1, 0, 4'd5);
    step(0, 2'b00, 1, 0, 1, 1, 0, 4'd2);
    step(0, 2'b00, 0, 0, 1, 1, 0, 4'd1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // dime then cancel: full refund
    step(1, 2'b10, 0, 0, 0, 0, 0, 4'd0);
    step(0, 2'b00, 1, 0, 0, 0, 0, 4'd2);
    step(0, 2'b00, 0, 0, 1, 1, 0, 4'd2);
    step(0, 2'b00, 0, 0, 1, 1, 0, 4'd1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // cancel with zero credit and valid null coin are both ignored
    step(0, 2'b00, 1, 0, 0, 0, 0, 4'd0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // coin + cancel without reaching price refunds the new sum
    step(1, 2'b01, 1, 0, 0, 0, 0, 4'd0);
    step(0, 2'b00, 0, 0, 1, 1, 0, 4'd1);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // coin + cancel reaching price vends, cancel dropped
    step(1, 2'b10, 0, 0, 0, 0, 0, 4'd0);
    step(1, 2'b01, 1, 0, 0, 0, 0, 4'd2);
    step(0, 2'b00, 0, 1, 0, 1, 0, 4'd3);
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
    // coins rejected while busy, then async reset mid-CHANGE
    step(1, 2'b11, 0, 0, 0, 0, 0, 4'd0);
    step(1, 2'b01, 0, 1, 0, 1, 1, 4'd5);
    step(1, 2'b01, 0, 0, 1, 1, 1, 4'd2);
    #2 reset = 1;
    #1;
    chk("mid_rst_vend", 8'(vend), 8'd0);
    chk("mid_rst_change", 8'(change), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    chk("mid_rst_reject", 8'(coin_reject), 8'd0);
    chk("mid_rst_credit", 8'(credit), 8'd0);
    coin_valid = 0;
    coin = 2'b00;
    #2 reset = 0;
    @(posedge clk);
    #1;
    step(0, 2'b00, 0, 0, 0, 0, 0, 4'd0);
`ifdef VEND_COUNT_EN
    // five purchases wrap the 2-bit counter: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      step(1, 2'b10, 0, 0, 0, 0, 0, 4'd0);
      step(1, 2'b01, 0, 0, 0, 0, 0, 4'd2);
      step(0, 2'b00, 0, 1, 0, 1, 0, 4'd3);
      chk("vend_count", 8'(vend_count), 8'((i + 1) % 4));
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
- Parametrised successor to the team's fixed 15-cent vending FSM.
- Price is a parameter, set in 5-cent units.
- Accepts 5/10/25-cent coins and holds a credit counter.
- Issues a one-cycle vend pulse and returns change serially, one 5-cent unit per cycle.
- Supports a cancel/refund request.
- Sits between the coin-acceptor front end and the dispense/change-hopper drivers.

Parameters:
- PRICE, 3, item price in 5-cent units (3 = 15c); legal range 1..(2**CREDIT_W - 5).
- CREDIT_W, 4, credit register width in 5-cent units; must hold PRICE-1+5.
- CNT_W, 8, width of the vend counter (used only with VEND_COUNT_EN).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- coin_valid  input  1  coin present this cycle.
- coin  input  2  coin code: 00 none, 01 = 5c (1 unit), 10 = 10c (2 units), 11 = 25c (5 units).
- cancel  input  1  request refund of the current credit.
- vend  output  1  one-cycle dispense pulse.
- change  output  1  one pulse per 5c unit returned.
- coin_reject  output  1  coin presented but not accepted this cycle (combinational).
- busy  output  1  high when the block is not in COLLECT.
- credit  output  CREDIT_W  current credit in 5c units (registered).
- vend_count  output  CNT_W  present only with VEND_COUNT_EN.

Behaviour:
- Reset (async, any time incl. mid-change):
  - state = COLLECT, credit = 0.
  - vend = change = coin_reject = busy = 0.
  - vend_count = 0.
- States: COLLECT, VEND, CHANGE.
- Outputs:
  - vend = (state == VEND).
  - change = (state == CHANGE).
  - busy = (state != COLLECT).
  - Accepted coin = coin_valid && coin != 00 && state == COLLECT.
- COLLECT:
  - Accepted coin: credit <= credit + value.
  - If credit + value >= PRICE: next = VEND. vend is high in the cycle after the completing coin (1-cycle latency).
  - cancel with credit > 0 and no completing coin: next = CHANGE (full refund).
  - Same-cycle accepted coin + cancel: coin is added first. If the sum reaches PRICE, vend wins and cancel is ignored; otherwise the whole new sum is refunded.
  - cancel with credit = 0: ignored.
  - coin = 00 with coin_valid: ignored, no reject.
- VEND:
  - credit <= credit - PRICE.
  - next = CHANGE if remainder > 0, else COLLECT.
- CHANGE:
  - change = 1 every cycle; credit decrements by 1 each cycle.
  - When credit == 1 this cycle: next = COLLECT (credit becomes 0).
  - Number of change pulses always equals the credit on entry.
- Rejection and inputs while busy:
  - coin_valid with coin != 00 in VEND or CHANGE: coin_reject = 1 the same cycle; credit unchanged.
  - cancel in VEND or CHANGE: ignored.
- Arithmetic:
  - All sums are computed at CREDIT_W+1 bits before compare.
  - The parameter constraint guarantees no overflow: max stored = PRICE-1+5.
- Elaboration:
  - Illegal PRICE/CREDIT_W combinations stop elaboration via a generate-time check.

Optional Feature:
- Macro VEND_COUNT_EN:
  - Defined: adds output vend_count[CNT_W-1:0]. It increments on each cycle with state == VEND and wraps from 2**CNT_W-1 to 0. It is cleared by reset.
  - Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- PRICE=3: coins 01,01,01 on cycles 1-3.
  - Required: vend = 1 on cycle 4 only; change never asserted; credit 1,2,3 then 0; busy low from cycle 5.
- PRICE=3: coins 10,10.
  - Required: vend on cycle 3; one change pulse on cycle 4; credit 4 → 1 → 0; back in COLLECT on cycle 5.
- PRICE=3: single coin 11 (25c).
  - Required: vend next cycle, then exactly 2 change pulses; credit 5 → 2 → 1 → 0.
- PRICE=3: coin 10, then cancel.
  - Required: no vend; exactly 2 change pulses; credit ends at 0.
- Coin during CHANGE, then reset in mid-CHANGE.
  - Coin 01 presented during CHANGE: coin_reject = 1 that cycle; credit unchanged; pulse count unaffected.
  - reset asserted between clock edges mid-CHANGE: outputs clear immediately; credit = 0; state = COLLECT.
- With VEND_COUNT_EN, CNT_W=2: five complete purchases.
  - Required: vend_count sequence 1, 2, 3, 0, 1 (wrap checked).
